mem_access_ctrl: RTL and testbench

//  Sequences one data-memory access per request for RISC-V loads/stores.

---
 rtl/mem_access_ctrl.sv | 205 ++++++++++++++++++++
 tb/tb_mem_access_ctrl.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_ctrl.sv
// Load/store access sequencer: alignment check, memory req/ack handshake, store lanes, load extension.
// Optional REQ timeout abort when MEM_ACCESS_TIMEOUT_EN is defined.
//
// state  | meaning
// IDLE   | ready for a request (reqReady_o=1)
// REQ    | memory request outstanding, waiting for memAck_i
// RESP   | one-cycle completion pulse (data, error or timeout)
module mem_access_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned TIMEOUT_W      = 8
) (
    input  logic        clk_i,
    input  logic        reset_n_i,
    input  logic        reqValid_i,
    output logic        reqReady_o,
    input  logic [6:0]  opcode_i,
    input  logic [2:0]  funct3_i,
    input  logic [63:0] address_i,
    input  logic [63:0] storeData_i,
    output logic        memReq_o,
    output logic        memWe_o,
    output logic [63:0] memAddr_o,
    output logic [63:0] memWData_o,
    output logic [7:0]  memByteEn_o,
    input  logic        memAck_i,
    input  logic [63:0] memRData_i,
    output logic        respValid_o,
    output logic [63:0] respData_o,
    output logic        err_o,
    output logic        busy_o
);

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_RESP = 2'd2
    } state_t;

    generate
        if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES >= (64'd1 << TIMEOUT_W)) begin : g_cfg_check
            $error("mem_access_ctrl: TIMEOUT_W too narrow for TIMEOUT_CYCLES");
        end
    endgenerate

    state_t      state_q, state_d;
    logic        we_q, we_d;
    logic [63:0] addr_q, addr_d;
    logic [63:0] wdata_q, wdata_d;
    logic [7:0]  be_q, be_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [2:0]  offset_q, offset_d;
    logic        load_q, load_d;
    logic        err_q, err_d;
    logic [63:0] rdata_q, rdata_d;

    logic        is_load, is_store, illegal, misalign, dec_go, dec_err, accept;
    logic [7:0]  size_mask;
    logic [63:0] lane, load_val;
    logic        timeout;

    always_comb begin
        is_load   = (opcode_i == OP_LOAD);
        is_store  = (opcode_i == OP_STORE);
        misalign  = 1'b0;
        size_mask = 8'h01;
        case (funct3_i[1:0])
            2'd0: begin misalign = 1'b0;                     size_mask = 8'h01; end
            2'd1: begin misalign = address_i[0];             size_mask = 8'h03; end
            2'd2: begin misalign = (address_i[1:0] != 2'd0); size_mask = 8'h0F; end
            2'd3: begin misalign = (address_i[2:0] != 3'd0); size_mask = 8'hFF; end
        endcase
        illegal = (is_load && funct3_i == 3'b111) || (is_store && funct3_i[2]);
        dec_go  = (is_load || is_store) && !illegal && !misalign;
        dec_err = (is_load || is_store) && (illegal || misalign);
        accept  = reqValid_i && (state_q == S_IDLE);
    end

    always_comb begin
        lane     = memRData_i >> {offset_q, 3'b000};
        load_val = lane;
        case (funct3_q[1:0])
            2'd0: load_val = funct3_q[2] ? {56'd0, lane[7:0]}  : {{56{lane[7]}},  lane[7:0]};
            2'd1: load_val = funct3_q[2] ? {48'd0, lane[15:0]} : {{48{lane[15]}}, lane[15:0]};
            2'd2: load_val = funct3_q[2] ? {32'd0, lane[31:0]} : {{32{lane[31]}}, lane[31:0]};
            2'd3: load_val = lane;
        endcase
    end

`ifdef MEM_ACCESS_TIMEOUT_EN
    localparam logic [TIMEOUT_W-1:0] TO_LAST = TIMEOUT_W'(TIMEOUT_CYCLES - 1);
    logic [TIMEOUT_W-1:0] to_cnt_q, to_cnt_d;

    always_comb begin
        to_cnt_d = to_cnt_q;
        if (accept && dec_go) begin
            to_cnt_d = '0;
        end else if (state_q == S_REQ && !memAck_i) begin
            to_cnt_d = to_cnt_q + 1'b1;
        end
    end

    // memAck_i in the last allowed cycle still completes the access normally.
    assign timeout = (state_q == S_REQ) && !memAck_i && (to_cnt_q == TO_LAST);

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            to_cnt_q <= '0;
        end else begin
            to_cnt_q <= to_cnt_d;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q  <= S_IDLE;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            be_q     <= '0;
            funct3_q <= '0;
            offset_q <= '0;
            load_q   <= 1'b0;
            err_q    <= 1'b0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            be_q     <= be_d;
            funct3_q <= funct3_d;
            offset_q <= offset_d;
            load_q   <= load_d;
            err_q    <= err_d;
            rdata_q  <= rdata_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        be_d     = be_q;
        funct3_d = funct3_q;
        offset_d = offset_q;
        load_d   = load_q;
        err_d    = err_q;
        rdata_d  = rdata_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    rdata_d = '0;
                    if (dec_go) begin
                        state_d  = S_REQ;
                        we_d     = is_store;
                        addr_d   = {address_i[63:3], 3'b000};
                        wdata_d  = storeData_i << {address_i[2:0], 3'b000};
                        be_d     = size_mask << address_i[2:0];
                        funct3_d = funct3_i;
                        offset_d = address_i[2:0];
                        load_d   = is_load;
                        err_d    = 1'b0;
                    end else begin
                        state_d = S_RESP;
                        err_d   = dec_err;
                    end
                end
            end
            S_REQ: begin
                if (memAck_i) begin
                    state_d = S_RESP;
                    err_d   = 1'b0;
                    rdata_d = load_q ? load_val : 64'd0;
                end else if (timeout) begin
                    state_d = S_RESP;
                    err_d   = 1'b1;
                    rdata_d = '0;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        reqReady_o  = (state_q == S_IDLE);
        busy_o      = (state_q != S_IDLE);
        memReq_o    = (state_q == S_REQ);
        memWe_o     = (state_q == S_REQ) && we_q;
        memAddr_o   = (state_q == S_REQ) ? addr_q  : 64'd0;
        memWData_o  = (state_q == S_REQ) ? wdata_q : 64'd0;
        memByteEn_o = (state_q == S_REQ) ? be_q    : 8'd0;
        respValid_o = (state_q == S_RESP);
        respData_o  = (state_q == S_RESP) ? rdata_q : 64'd0;
        err_o       = (state_q == S_RESP) && err_q;
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: vector table plus hand sequences for
// handshake delay, stray ack, ignored requests, timeout and async reset.
module tb_mem_access_ctrl;

    localparam logic [6:0] LOAD  = 7'b0000011;
    localparam logic [6:0] STORE = 7'b0100011;
    localparam logic [6:0] RTYPE = 7'b0110011;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        reqValid = 1'b0;
    logic        reqReady;
    logic [6:0]  opcode = '0;
    logic [2:0]  funct3 = '0;
    logic [63:0] address = '0;
    logic [63:0] storeData = '0;
    logic        memReq, memWe;
    logic [63:0] memAddr, memWData;
    logic [7:0]  memByteEn;
    logic        memAck = 1'b0;
    logic [63:0] memRData = '0;
    logic        respValid;
    logic [63:0] respData;
    logic        err, busy;

    int n_chk = 0;
    int n_pass = 0;
    int n_resp = 0;
    int exp_resp = 0;

    always #5 clk = ~clk;

    always @(negedge clk) if (respValid) n_resp++;

    mem_access_ctrl #(.TIMEOUT_CYCLES(4), .TIMEOUT_W(8)) dut (
        .clk_i(clk), .reset_n_i(reset_n),
        .reqValid_i(reqValid), .reqReady_o(reqReady),
        .opcode_i(opcode), .funct3_i(funct3), .address_i(address), .storeData_i(storeData),
        .memReq_o(memReq), .memWe_o(memWe), .memAddr_o(memAddr), .memWData_o(memWData),
        .memByteEn_o(memByteEn), .memAck_i(memAck), .memRData_i(memRData),
        .respValid_o(respValid), .respData_o(respData), .err_o(err), .busy_o(busy)
    );

    typedef struct {
        string       name;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [63:0] addr;
        logic [63:0] sdata;
        logic [63:0] rdata;
        int          delay;
        bit          access;
        bit          we;
        logic [63:0] maddr;
        logic [7:0]  be;
        logic [63:0] wdata;
        logic [63:0] resp;
        bit          err;
    } vec_t;

    vec_t vecs[15];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic [6:0] op, input logic [2:0] f3,
                           input logic [63:0] a, input logic [63:0] sd);
        reqValid  = 1'b1;
        opcode    = op;
        funct3    = f3;
        address   = a;
        storeData = sd;
    endtask

    task automatic run_vec(input vec_t v);
        present(v.op, v.f3, v.addr, v.sdata);
        chk({v.name, ".reqReady"}, 64'(reqReady), 64'd1);
        cyc();
        reqValid = 1'b0;
        if (v.access) begin
            chk({v.name, ".memReq"}, 64'(memReq), 64'd1);
            chk({v.name, ".memWe"}, 64'(memWe), 64'(v.we));
            chk({v.name, ".memAddr"}, memAddr, v.maddr);
            chk({v.name, ".memByteEn"}, 64'(memByteEn), 64'(v.be));
            chk({v.name, ".memWData"}, memWData, v.wdata);
            chk({v.name, ".busy"}, 64'(busy), 64'd1);
            chk({v.name, ".early_resp"}, 64'(respValid), 64'd0);
            for (int i = 0; i < v.delay; i++) begin
                cyc();
                chk({v.name, ".hold_req"}, 64'(memReq), 64'd1);
                chk({v.name, ".hold_addr"}, memAddr, v.maddr);
                chk({v.name, ".hold_wdata"}, memWData, v.wdata);
                chk({v.name, ".hold_ready"}, 64'(reqReady), 64'd0);
                chk({v.name, ".hold_resp"}, 64'(respValid), 64'd0);
            end
            memAck   = 1'b1;
            memRData = v.rdata;
            cyc();
            memAck = 1'b0;
        end else begin
            chk({v.name, ".no_req"}, 64'(memReq), 64'd0);
        end
        chk({v.name, ".respValid"}, 64'(respValid), 64'd1);
        chk({v.name, ".respData"}, respData, v.resp);
        chk({v.name, ".err"}, 64'(err), 64'(v.err));
        chk({v.name, ".memReq_resp"}, 64'(memReq), 64'd0);
        exp_resp++;
        cyc();
        chk({v.name, ".pulse_end"}, 64'(respValid), 64'd0);
        chk({v.name, ".idle_ready"}, 64'(reqReady), 64'd1);
    endtask

    initial begin
        vecs[0]  = '{"lb_sext",  LOAD,  3'b000, 64'h3,   64'h0, 64'h0000_0000_8000_0000, 0, 1, 0, 64'h0,   8'h08, 64'h0, 64'hFFFF_FFFF_FFFF_FF80, 0};
        vecs[1]  = '{"lhu",      LOAD,  3'b101, 64'h6,   64'h0, 64'hBEEF_0000_0000_0000, 0, 1, 0, 64'h0,   8'hC0, 64'h0, 64'h0000_0000_0000_BEEF, 0};
        vecs[2]  = '{"sw",       STORE, 3'b010, 64'h104, 64'h1122_3344_5566_7788, 64'h0, 0, 1, 1, 64'h100, 8'hF0, 64'h5566_7788_0000_0000, 64'h0, 0};
        vecs[3]  = '{"lw_misal", LOAD,  3'b010, 64'h2,   64'h0, 64'h0, 0, 0, 0, 64'h0, 8'h00, 64'h0, 64'h0, 1};
        vecs[4]  = '{"ld",       LOAD,  3'b011, 64'h8,   64'h0, 64'h0123_4567_89AB_CDEF, 0, 1, 0, 64'h8,   8'hFF, 64'h0, 64'h0123_4567_89AB_CDEF, 0};
        vecs[5]  = '{"lh_sext",  LOAD,  3'b001, 64'h2A,  64'h0, 64'h0000_0000_8001_0000, 1, 1, 0, 64'h28,  8'h0C, 64'h0, 64'hFFFF_FFFF_FFFF_8001, 0};
        vecs[6]  = '{"lwu_slow", LOAD,  3'b110, 64'h14,  64'h0, 64'hF00D_CAFE_0000_0000, 5, 1, 0, 64'h10,  8'hF0, 64'h0, 64'h0000_0000_F00D_CAFE, 0};
        vecs[7]  = '{"lw_sext",  LOAD,  3'b010, 64'h1C,  64'h0, 64'h8000_0001_0000_0000, 2, 1, 0, 64'h18,  8'hF0, 64'h0, 64'hFFFF_FFFF_8000_0001, 0};
        vecs[8]  = '{"ld_f111",  LOAD,  3'b111, 64'h0,   64'h0, 64'h0, 0, 0, 0, 64'h0, 8'h00, 64'h0, 64'h0, 1};
        vecs[9]  = '{"st_f100",  STORE, 3'b100, 64'h0,   64'h5, 64'h0, 0, 0, 0, 64'h0, 8'h00, 64'h0, 64'h0, 1};
        vecs[10] = '{"non_ls",   RTYPE, 3'b000, 64'h0,   64'h0, 64'h0, 0, 0, 0, 64'h0, 8'h00, 64'h0, 64'h0, 0};
        vecs[11] = '{"sb_top",   STORE, 3'b000, 64'h7,   64'hAB, 64'h0, 0, 1, 1, 64'h0,  8'h80, 64'hAB00_0000_0000_0000, 64'h0, 0};
        vecs[12] = '{"sd_misal", STORE, 3'b011, 64'h4,   64'h0, 64'h0, 0, 0, 0, 64'h0, 8'h00, 64'h0, 64'h0, 1};
        vecs[13] = '{"sh_misal", STORE, 3'b001, 64'h3,   64'h0, 64'h0, 0, 0, 0, 64'h0, 8'h00, 64'h0, 64'h0, 1};
        vecs[14] = '{"lbu",      LOAD,  3'b100, 64'h5,   64'h0, 64'h0000_FF00_0000_0000, 0, 1, 0, 64'h0,  8'h20, 64'h0, 64'h0000_0000_0000_00FF, 0};

        // Reset state
        cyc();
        cyc();
        chk("rst.reqReady", 64'(reqReady), 64'd1);
        chk("rst.busy", 64'(busy), 64'd0);
        chk("rst.memReq", 64'(memReq), 64'd0);
        chk("rst.memByteEn", 64'(memByteEn), 64'd0);
        chk("rst.respValid", 64'(respValid), 64'd0);
        chk("rst.err", 64'(err), 64'd0);
        reset_n = 1'b1;
        cyc();

        foreach (vecs[i]) run_vec(vecs[i]);

        // Stray memAck in IDLE
        memAck   = 1'b1;
        memRData = '1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("stray.respValid", 64'(respValid), 64'd0);
            chk("stray.busy", 64'(busy), 64'd0);
            chk("stray.memReq", 64'(memReq), 64'd0);
        end
        memAck = 1'b0;

        // reqValid during REQ is ignored
        present(LOAD, 3'b011, 64'h40, 64'h0);
        cyc();
        present(LOAD, 3'b010, 64'h1, 64'h0);
        for (int i = 0; i < 2; i++) begin
            cyc();
            chk("ign.memAddr", memAddr, 64'h40);
            chk("ign.memReq", 64'(memReq), 64'd1);
        end
        reqValid = 1'b0;
        memAck   = 1'b1;
        memRData = 64'h0000_0000_DEAD_0001;
        cyc();
        memAck = 1'b0;
        chk("ign.respValid", 64'(respValid), 64'd1);
        chk("ign.err", 64'(err), 64'd0);
        chk("ign.respData", respData, 64'h0000_0000_DEAD_0001);
        exp_resp++;
        cyc();
        cyc();
        chk("ign.no_second", 64'(busy), 64'd0);

`ifdef MEM_ACCESS_TIMEOUT_EN
        present(LOAD, 3'b011, 64'h30, 64'h0);
        cyc();
        reqValid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) cyc();
            chk("to.memReq_held", 64'(memReq), 64'd1);
        end
        cyc();
        chk("to.memReq_drop", 64'(memReq), 64'd0);
        chk("to.respValid", 64'(respValid), 64'd1);
        chk("to.err", 64'(err), 64'd1);
        chk("to.respData", respData, 64'd0);
        exp_resp++;
        cyc();

        // ack in the final allowed cycle beats the timeout
        present(LOAD, 3'b011, 64'h30, 64'h0);
        cyc();
        reqValid = 1'b0;
        cyc();
        cyc();
        cyc();
        chk("to_ack.memReq", 64'(memReq), 64'd1);
        memAck   = 1'b1;
        memRData = 64'h1234;
        cyc();
        memAck = 1'b0;
        chk("to_ack.respValid", 64'(respValid), 64'd1);
        chk("to_ack.err", 64'(err), 64'd0);
        chk("to_ack.respData", respData, 64'h1234);
        exp_resp++;
        cyc();
`else
        present(LOAD, 3'b011, 64'h30, 64'h0);
        cyc();
        reqValid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cyc();
            chk("wait.memReq", 64'(memReq), 64'd1);
            chk("wait.respValid", 64'(respValid), 64'd0);
        end
        memAck   = 1'b1;
        memRData = 64'h1234;
        cyc();
        memAck = 1'b0;
        chk("wait.respValid_end", 64'(respValid), 64'd1);
        chk("wait.err", 64'(err), 64'd0);
        chk("wait.respData", respData, 64'h1234);
        exp_resp++;
        cyc();
`endif

        // Async reset while REQ is outstanding
        present(LOAD, 3'b011, 64'h50, 64'h0);
        cyc();
        reqValid = 1'b0;
        chk("rstreq.memReq_before", 64'(memReq), 64'd1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("rstreq.memReq_now", 64'(memReq), 64'd0);
        chk("rstreq.busy", 64'(busy), 64'd0);
        chk("rstreq.reqReady", 64'(reqReady), 64'd1);
        cyc();
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("rstreq.no_resp", 64'(respValid), 64'd0);
        end

        chk("resp_pulse_count", 64'(n_resp), 64'(exp_resp));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
